// File: rtl/nn_pkg.sv
// Shared definitions for the neural-net readout blocks: default layer
// geometry, the argmax controller state encoding, and an index-width helper.
package nn_pkg;

    localparam int DEFAULT_WIDTH       = 16;
    localparam int DEFAULT_OUTPUT_SIZE = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } argmax_state_t;

    // Width of an index into an n-entry vector; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/score_cmp.sv
// Signed magnitude comparator: a_gt_b is high when a > b as two's complement.
module score_cmp #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             a_gt_b
);

    // Strict greater-than so equal scores never displace the earlier winner.
    assign a_gt_b = $signed(a) > $signed(b);

endmodule

// File: rtl/layer_argmax_reader.sv
// Argmax readout of a dense-layer output vector. A vector is captured in one
// cycle, scanned one entry per cycle, and the winning index/value is held
// behind a valid/ready handshake until downstream takes it.
module layer_argmax_reader
    import nn_pkg::*;
#(
    parameter int OUTPUT_SIZE = DEFAULT_OUTPUT_SIZE,
    parameter int WIDTH       = DEFAULT_WIDTH,
    localparam int IDXW       = idx_width(OUTPUT_SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] scores [OUTPUT_SIZE],
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IDXW-1:0]  class_idx,
    output logic [WIDTH-1:0] max_val,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(OUTPUT_SIZE - 1);
    localparam logic [IDXW-1:0] FIRST_SCAN_IDX = IDXW'(1);

    argmax_state_t    state_q;
    argmax_state_t    state_d;
    logic [WIDTH-1:0] score_buf [OUTPUT_SIZE];
    logic [IDXW-1:0]  scan_idx;
    logic [IDXW-1:0]  best_idx;
    logic [WIDTH-1:0] best_val;
    logic [WIDTH-1:0] cur_score;
    logic             cur_gt_best;
    logic             accept;
    logic             scan_last;

    assign accept    = (state_q == IDLE) && in_valid;
    assign scan_last = (scan_idx == LAST_IDX);
    assign cur_score = score_buf[scan_idx];

    score_cmp #(.WIDTH(WIDTH)) u_cmp (
        .a      (cur_score),
        .b      (best_val),
        .a_gt_b (cur_gt_best)
    );

    // State register; reset wins over any handshake in the same cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples pre-edge values regardless of block ordering.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = SCAN;
            SCAN:    if (scan_last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register only.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Snapshot of the input vector taken only on the accepting edge.
    always_ff @(posedge clk) begin
        // NOTE: the buffer is deliberately not reset; its contents are only
        // read after a fresh capture, and leaving it out keeps it a plain RAM.
        if (accept) begin
            for (int i = 0; i < OUTPUT_SIZE; i++) begin
                score_buf[i] <= scores[i];
            end
        end
    end

    // Scan datapath: running best, index counter and the published result.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_idx  <= '0;
            best_idx  <= '0;
            best_val  <= '0;
            class_idx <= '0;
            max_val   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        best_val <= scores[0];
                        best_idx <= '0;
                        scan_idx <= FIRST_SCAN_IDX;
                    end
                end
                SCAN: begin
                    if (cur_gt_best) begin
                        best_val <= cur_score;
                        best_idx <= scan_idx;
                    end
                    if (scan_last) begin
                        class_idx <= cur_gt_best ? scan_idx  : best_idx;
                        max_val   <= cur_gt_best ? cur_score : best_val;
                        scan_idx  <= '0;
                    end else begin
                        scan_idx <= scan_idx + FIRST_SCAN_IDX;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/layer_argmax_reader.md
LAYER_ARGMAX_READER -- requirements
Module: layer_argmax_reader

Interface
REQ-001 SHALL have parameter OUTPUT_SIZE, default 10: number of layer output scores consumed; legal range >= 2.
REQ-002 SHALL have parameter WIDTH, default 16: bit width of each score.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port scores  input  [WIDTH-1:0] x OUTPUT_SIZE (unpacked array)  layer output vector, same shape as the dense-layer outputs.
REQ-006 SHALL have port in_valid  input  1  scores vector valid.
REQ-007 SHALL have port in_ready  output  1  block can accept a vector.
REQ-008 SHALL have port class_idx  output  IDXW = max(1, clog2(OUTPUT_SIZE))  index of the maximum score.
REQ-009 SHALL have port max_val  output  WIDTH  value of the maximum score.
REQ-010 SHALL have port out_valid  output  1  class_idx/max_val valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result.

Function
REQ-012 SHALL implement FSM states IDLE, SCAN, DONE.
REQ-013 In IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready at an edge, SHALL capture all OUTPUT_SIZE scores into an internal buffer, set best_val=scores[0], best_idx=0, scan index=1, and go to SCAN.
REQ-014 scores SHALL be sampled only at the accepting edge; later changes on scores SHALL NOT affect the result.
REQ-015 In SCAN: one buffer entry per cycle; if buf[idx] > best_val, then best_val=buf[idx] and best_idx=idx; idx increments.
REQ-016 Comparison SHALL be signed two's complement over WIDTH bits.
REQ-017 Ties SHALL keep the earlier (lowest) index; strict greater-than only.
REQ-018 The SCAN step processing idx=OUTPUT_SIZE-1 SHALL transition to DONE.
REQ-019 out_valid SHALL rise exactly OUTPUT_SIZE-1 edges after the accepting edge (9 for default).
REQ-020 In DONE: out_valid=1, in_ready=0; class_idx and max_val SHALL hold stable until out_valid&&out_ready.
REQ-021 On out_valid&&out_ready SHALL return to IDLE; in_ready SHALL be 1 the following cycle; no new accept occurs in the same cycle as the output handshake.
REQ-022 in_ready SHALL be 0 throughout SCAN and DONE; in_valid in those states SHALL be ignored.
REQ-023 class_idx/max_val SHALL update only on the SCAN->DONE transition; they SHALL retain the previous result in IDLE and SCAN.
REQ-024 Combinational path from in_valid or out_ready to any output SHALL NOT exist; all outputs are register-driven.

Reset
REQ-025 On rst=1 at an edge, SHALL enter IDLE from any state, including mid-SCAN or DONE with a pending result.
REQ-026 Reset values: in_ready=1 (after reset edge), out_valid=0, class_idx=0, max_val=0, scan index=0, buffer contents don't-care.
REQ-027 rst SHALL take priority over every handshake in the same cycle; a result pending in DONE SHALL be discarded.

Structure
REQ-028 Shared package nn_pkg SHALL hold default WIDTH, default OUTPUT_SIZE, and the FSM state enum type.
REQ-029 Signed compare SHALL be a sub-module score_cmp (inputs a, b; output a_gt_b, signed, parameterised by WIDTH).
REQ-030 Buffer, FSM, index counter and best registers SHALL live in layer_argmax_reader; no other sub-modules.

Verification (OUTPUT_SIZE=10, WIDTH=16)
REQ-031 scores = {5,3,9,1,0,2,7,8,4,6} (index 0 first), out_ready=1 -> class_idx=2, max_val=9, out_valid rises 9 edges after accept.
REQ-032 All scores negative {-100,-7,-50,...,-9 at idx 9} -> class_idx=1, max_val=-7 (0xFFF9); checks signed compare.
REQ-033 Ties: 42 at indices 3 and 8, rest 0 -> class_idx=3, max_val=42.
REQ-034 out_ready=0 for 20 cycles after out_valid, scores input changed and in_valid held 1 -> outputs stable, in_ready=0, no second accept; on out_ready=1 -> IDLE, next vector accepted the following cycle.
REQ-035 rst asserted 4 cycles into SCAN -> next cycle IDLE, out_valid=0, class_idx=0, max_val=0; fresh vector {0,...,0,1 at idx 9} -> class_idx=9, max_val=1.
REQ-036 Back-to-back: two vectors with in_valid continuously high, out_ready=1 -> both results correct and in order, each accept one cycle after prior output handshake.
